order_msg_encoder: RTL and testbench

// - Outbound counterpart of the order decoder/parser: accepts one parsed order
//   (book_entry fields price/order_id/quantity + side bit) per handshake.
// - Serializes each order into a big-endian byte stream for the egress MAC/FIFO.
// - Sits between the strategy/book logic and the line-side byte interface.

---
 rtl/order_msg_encoder.sv | 172 +++++++++++++++++
 tb/tb_order_msg_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_msg_encoder.sv
// Order message encoder: turns one accepted order into a big-endian byte stream
// (type, side, order_id, price, quantity). Define ORDER_MSG_CHECKSUM_EN to append an XOR checksum byte.
module order_msg_encoder #(
  parameter int         PRICE_W  = 16,
  parameter int         ID_W     = 8,
  parameter int         QTY_W    = 8,
  parameter logic [7:0] MSG_TYPE = 8'h41
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PRICE_W-1:0] in_price,
  input  logic [ID_W-1:0]    in_order_id,
  input  logic [QTY_W-1:0]   in_quantity,
  input  logic               in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_sop,
  output logic               out_eop
);

  if ((PRICE_W % 8) != 0 || (ID_W % 8) != 0 || (QTY_W % 8) != 0) begin : g_bad_width
    $error("order_msg_encoder: field widths must be multiples of 8");
  end

  localparam int BASE_N = 2 + (ID_W + PRICE_W + QTY_W) / 8;
`ifdef ORDER_MSG_CHECKSUM_EN
  localparam int MSG_N  = BASE_N + 1;
`else
  localparam int MSG_N  = BASE_N;
`endif
  localparam int MSG_W  = MSG_N * 8;
  localparam int CNT_W  = $clog2(MSG_N);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(MSG_N - 1);
  localparam logic [7:0]       SIDE_BUY  = 8'h42;
  localparam logic [7:0]       SIDE_SELL = 8'h53;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_sop;
  logic             r_out_eop;
  logic [CNT_W-1:0] r_cnt;
  logic [MSG_W-1:0] r_msg;  // bytes not yet presented, next one in the top byte

  logic              w_accept;
  logic              w_fire;
  logic              w_last_fire;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [BASE_N*8-1:0] w_base;
  logic [MSG_W-1:0]  w_msg_in;
  logic              w_nxt_ready;
  logic              w_nxt_valid;
  logic [7:0]        w_nxt_data;
  logic              w_nxt_sop;
  logic              w_nxt_eop;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [MSG_W-1:0]  w_nxt_msg;

  assign w_base = {MSG_TYPE, (in_side ? SIDE_BUY : SIDE_SELL), in_order_id, in_price, in_quantity};

`ifdef ORDER_MSG_CHECKSUM_EN
  logic [7:0] w_csum;

  always_comb begin
    w_csum = '0;
    for (int i = 0; i < BASE_N; i++) w_csum = w_csum ^ w_base[8*i +: 8];
  end

  assign w_msg_in = {w_base, w_csum};
`else
  assign w_msg_in = w_base;
`endif

  assign w_accept    = in_valid && r_in_ready;
  assign w_fire      = r_out_valid && out_ready;
  assign w_last_fire = w_fire && r_out_eop;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  // NOTE: sequential state is written with non-blocking (<=) so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: each always_comb target gets a default first, so no branch can infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next_state = S_SEND;
      S_SEND:  if (w_last_fire) w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; they only move on accept or on a byte handshake.
  always_comb begin
    w_nxt_valid = r_out_valid;
    w_nxt_data  = r_out_data;
    w_nxt_sop   = r_out_sop;
    w_nxt_eop   = r_out_eop;
    w_nxt_cnt   = r_cnt;
    w_nxt_msg   = r_msg;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_valid = 1'b1;
          w_nxt_data  = w_msg_in[MSG_W-1 -: 8];
          w_nxt_sop   = 1'b1;
          w_nxt_eop   = 1'b0;
          w_nxt_cnt   = '0;
          w_nxt_msg   = w_msg_in << 8;
        end
      end
      S_SEND: begin
        if (w_last_fire) begin
          w_nxt_valid = 1'b0;
          w_nxt_data  = '0;
          w_nxt_sop   = 1'b0;
          w_nxt_eop   = 1'b0;
          w_nxt_cnt   = '0;
        end else if (w_fire) begin
          w_nxt_data  = r_msg[MSG_W-1 -: 8];
          w_nxt_sop   = 1'b0;
          w_nxt_eop   = (w_cnt_inc == LAST_IDX);
          w_nxt_cnt   = w_cnt_inc;
          w_nxt_msg   = r_msg << 8;
        end
      end
      default: begin
        w_nxt_valid = 1'b0;
      end
    endcase
    w_nxt_ready = (w_next_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_in_ready  <= w_nxt_ready;
      r_out_valid <= w_nxt_valid;
      r_out_data  <= w_nxt_data;
      r_out_sop   <= w_nxt_sop;
      r_out_eop   <= w_nxt_eop;
      r_cnt       <= w_nxt_cnt;
    end
  end

  // NOTE: the message holding register is pure datapath qualified by r_out_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    r_msg <= w_nxt_msg;
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;

endmodule

// File: tb/tb_order_msg_encoder.sv
// Bench for order_msg_encoder: byte-queue reference model checked every cycle,
// plus directed literal sequences for buy/sell, back-to-back, stall and mid-message reset.
`timescale 1ns/1ps
module tb_order_msg_encoder;

  localparam int BASE_N  = 6;
`ifdef ORDER_MSG_CHECKSUM_EN
  localparam int NB      = BASE_N + 1;
`else
  localparam int NB      = BASE_N;
`endif
  localparam int LOG_MAX = 4096;

  bit          clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_price = '0;
  logic [7:0]  in_order_id = '0;
  logic [7:0]  in_quantity = '0;
  logic        in_side = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;

  always #5 clk = ~clk;

  order_msg_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_price    (in_price),
    .in_order_id (in_order_id),
    .in_quantity (in_quantity),
    .in_side     (in_side),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sop     (out_sop),
    .out_eop     (out_eop)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  int         n_acc    = 0;
  int         got_n    = 0;
  bit         armed    = 1'b0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_snap = '0;
  int         rmode    = 0;

  logic [7:0] got_d   [LOG_MAX];
  bit         got_sop [LOG_MAX];
  bit         got_eop [LOG_MAX];
  int         got_cyc [LOG_MAX];

`ifdef ORDER_MSG_CHECKSUM_EN
  logic [7:0] v1_exp [NB] = '{8'h41, 8'h42, 8'h07, 8'h12, 8'h34, 8'h0A, 8'h28};
  logic [7:0] v2_exp [NB] = '{8'h41, 8'h53, 8'h5A, 8'hBE, 8'hEF, 8'hC3, 8'hDA};
  logic [7:0] v3_exp [NB] = '{8'h41, 8'h53, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12};
`else
  logic [7:0] v1_exp [NB] = '{8'h41, 8'h42, 8'h07, 8'h12, 8'h34, 8'h0A};
  logic [7:0] v2_exp [NB] = '{8'h41, 8'h53, 8'h5A, 8'hBE, 8'hEF, 8'hC3};
  logic [7:0] v3_exp [NB] = '{8'h41, 8'h53, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted order becomes NB expected bytes on the output queue.
  function automatic void model_push(input logic [15:0] p, input logic [7:0] id,
                                     input logic [7:0] q, input logic s);
    logic [7:0] b [NB];
    exp_t       e;
    b[0] = 8'h41;
    b[1] = s ? 8'h42 : 8'h53;
    b[2] = id;
    b[3] = p[15:8];
    b[4] = p[7:0];
    b[5] = q;
`ifdef ORDER_MSG_CHECKSUM_EN
    b[6] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
`endif
    for (int i = 0; i < NB; i++) begin
      e.d   = b[i];
      e.sop = (i == 0);
      e.eop = (i == NB - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    bit   idle;
    exp_t f;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      armed      = 1'b0;
      prev_stall = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sop", out_sop, 0);
      check("rst_out_eop", out_eop, 0);
      check("rst_in_ready", in_ready, 0);
    end else begin
      idle = (exp_q.size() == 0);
      check("in_ready", in_ready, armed && idle);
      check("out_valid", out_valid, !idle);
      if (!idle) begin
        f = exp_q[0];
        check("out_data", out_data, f.d);
        check("out_sop", out_sop, f.sop);
        check("out_eop", out_eop, f.eop);
        if (prev_stall) check("stall_hold", {out_data, out_sop, out_eop}, prev_snap);
        if (out_ready) begin
          if (got_n < LOG_MAX) begin
            got_d[got_n]   = out_data;
            got_sop[got_n] = out_sop;
            got_eop[got_n] = out_eop;
            got_cyc[got_n] = cyc;
            got_n++;
          end
          void'(exp_q.pop_front());
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_snap  = {out_data, out_sop, out_eop};
        end
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && armed && idle) begin
        model_push(in_price, in_order_id, in_quantity, in_side);
        acc_cyc = cyc;
        n_acc++;
      end
      armed = 1'b1;
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = random, 3 = held low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send_order(input logic [15:0] p, input logic [7:0] id, input logic [7:0] q,
                            input logic s, input bit hold);
    int waited = 0;
    @(posedge clk); #1;
    in_price    = p;
    in_order_id = id;
    in_quantity = q;
    in_side     = s;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int target, input int limit);
    int n = 0;
    while (got_n < target && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    check("byte_wait", got_n >= target, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < limit) begin
      @(posedge clk); #2;
      n++;
    end
    check("idle_wait", (exp_q.size() == 0) && in_ready, 1);
  endtask

  task automatic check_seq(input string name, input int base, input logic [7:0] exp [NB]);
    for (int i = 0; i < NB; i++) begin
      check({name, "_byte"}, got_d[base+i], exp[i]);
      check({name, "_flags"}, {got_sop[base+i], got_eop[base+i]}, {(i == 0), (i == NB - 1)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int acc0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", in_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", in_ready, 1);

    // Single buy, downstream always ready.
    base = got_n;
    send_order(16'h1234, 8'h07, 8'h0A, 1'b1, 1'b0);
    wait_bytes(base + NB, 50);
    check_seq("buy", base, v1_exp);
    check("first_byte_latency", got_cyc[base], acc_cyc + 1);
    wait_idle(50);

    // Sell with out_ready toggling every cycle.
    rmode = 1;
    base = got_n;
    send_order(16'hBEEF, 8'h5A, 8'hC3, 1'b0, 1'b0);
    wait_bytes(base + NB, 100);
    check_seq("sell_toggle", base, v2_exp);
    rmode = 0;
    wait_idle(50);

    // Two orders with in_valid held high across the first message.
    base = got_n;
    send_order(16'h0102, 8'h11, 8'h22, 1'b1, 1'b1);
    send_order(16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_bytes(base + 2 * NB, 200);
    check("b2b_gap", got_cyc[base+NB], got_cyc[base+NB-1] + 2);
    check_seq("b2b_second", base + NB, v3_exp);
    wait_idle(50);

    // Reset pulsed after the third byte, then a fresh complete message.
    base = got_n;
    send_order(16'h1234, 8'h07, 8'h0A, 1'b1, 1'b0);
    wait_bytes(base + 3, 50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sop", out_sop, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = got_n;
    send_order(16'h1234, 8'h07, 8'h0A, 1'b1, 1'b0);
    wait_bytes(base + NB, 50);
    check_seq("after_rst", base, v1_exp);
    wait_idle(50);

    // Stall 20 cycles on byte 0.
    rmode = 3;
    repeat (2) @(posedge clk);
    base = got_n;
    send_order(16'h1234, 8'h07, 8'h0A, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    check("stall_valid", out_valid, 1);
    check("stall_sop", out_sop, 1);
    check("stall_data", out_data, 8'h41);
    check("stall_in_ready", in_ready, 0);
    check("stall_no_fire", got_n, base);
    rmode = 0;
    wait_bytes(base + NB, 50);
    check_seq("stall", base, v1_exp);
    wait_idle(50);

    // Randomized orders under random backpressure.
    rmode = 2;
    base = got_n;
    acc0 = n_acc;
    for (int i = 0; i < 150; i++) begin
      logic [15:0] rp;
      logic [7:0]  rid;
      logic [7:0]  rq;
      logic        rs;
      bit          rh;
      rp  = 16'($urandom);
      rid = 8'($urandom);
      rq  = 8'($urandom);
      rs  = 1'($urandom_range(0, 1));
      rh  = ($urandom_range(0, 3) == 0) && (i < 149);
      send_order(rp, rid, rq, rs, rh);
      if (!rh) repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle(2000);
    check("rand_accepts", n_acc - acc0, 150);
    check("rand_bytes", got_n - base, 150 * NB);
    rmode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
